output_unit: RTL and testbench
==============================

OUTPUT_UNIT -- requirements
Module: output_unit

Interface
REQ-001 SHALL have parameter FLIT_SIZE, default router_pkg FLIT_SIZE, meaning flit width; bit FLIT_SIZE-1 is the flit valid bit.
REQ-002 SHALL have parameter DEPTH, default 8, meaning output buffer capacity in flits (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_flit  input  FLIT_t  flit from the switch; type field is i_flit.tail.flit_type (router_pkg encoding).
REQ-006 SHALL have port i_flit_push  input  1  write i_flit into the buffer this cycle.
REQ-007 SHALL have port o_flit_ready  output  1  buffer not full; a push is accepted only when high.
REQ-008 SHALL have port o_flit  output  FLIT_t  flit driven to the downstream input unit.
REQ-009 SHALL have port o_downstream_req  output  1  request for the downstream input port.
REQ-010 SHALL have port i_transmit_ack  input  1  grant from the downstream input port.
REQ-011 SHALL have port o_busy  output  1  high in REQUEST or SEND.
REQ-012 SHALL have port o_pkt_count  output  $clog2(DEPTH)+1  complete packets (tails) held in the buffer.

Function
REQ-013 SHALL contain a DEPTH-entry circular FIFO with read/write pointers and an occupancy counter of $clog2(DEPTH)+1 bits; pointers wrap from DEPTH-1 to 0.
REQ-014 SHALL write i_flit on a clock edge where i_flit_push && o_flit_ready; a push while full SHALL be dropped with no state change.
REQ-015 SHALL derive o_flit_ready = (occupancy != DEPTH) combinationally.
REQ-016 SHALL increment o_pkt_count on an accepted push of a TAIL_FLIT and decrement it when a TAIL_FLIT is popped; both on one edge SHALL leave it unchanged.
REQ-017 SHALL allow a simultaneous push and pop when full: the pop frees the slot only after the edge, so the push is dropped (ready is low).
REQ-018 SHALL implement registered FSM states IDLE, REQUEST, SEND.
REQ-019 IDLE: o_downstream_req=0, o_flit='0; if o_pkt_count>0 at an edge, go to REQUEST with o_downstream_req registered to 1 on that edge.
REQ-020 REQUEST: hold o_downstream_req=1 and o_flit='0 indefinitely until i_transmit_ack is sampled high; i_transmit_ack in IDLE or SEND SHALL be ignored.
REQ-021 On the edge sampling i_transmit_ack=1 in REQUEST: go to SEND, drop o_downstream_req to 0, pop the head-of-FIFO flit into o_flit with bit FLIT_SIZE-1 forced to 1.
REQ-022 SEND: pop and register exactly one flit per edge into o_flit (valid bit forced 1), no bubbles, until the popped flit is TAIL_FLIT.
REQ-023 On the edge after the tail is registered, o_flit SHALL become '0 (valid bit 0) and state SHALL return to IDLE; REQUEST may be entered on the following edge.
REQ-024 Latency: tail pushed at edge N -> o_downstream_req high after edge N+1; ack sampled at edge M -> head on o_flit after M, k-flit packet tail after M+k-1, o_flit='0 after M+k.
REQ-025 The FIFO is never empty in SEND (a counted tail guarantees data); a pop from empty SHALL not occur and SHALL raise a simulation assertion.
REQ-026 o_busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-027 While reset_n=0 (at any time, including mid-SEND), state=IDLE, pointers/occupancy/o_pkt_count=0, o_flit='0, o_downstream_req=0, o_busy=0, buffered flits discarded.
REQ-028 After reset release, o_flit_ready SHALL be 1 and the first edge SHALL behave as IDLE.

Verification
REQ-029 Push HEAD,BODY,TAIL (DEPTH=8) at edges 1-3 -> req=1 after edge 4; ack high sampled edge 7 -> req=0, flits on o_flit after edges 7,8,9 with valid=1, o_flit='0 after edge 10, o_pkt_count 1->0.
REQ-030 Push 9 flits without tail, no pops -> o_flit_ready=0 after 8th, 9th dropped, o_pkt_count=0, req stays 0.
REQ-031 Packet buffered, ack held 0 for 100 cycles -> req stays 1, o_flit='0 throughout; spurious ack in IDLE -> no state change.
REQ-032 Two 2-flit packets buffered -> after first tail, IDLE one cycle, req re-asserted next edge, second packet sent after second ack, o_pkt_count 2->1->0.
REQ-033 Push a TAIL while SEND pops a TAIL on the same edge -> o_pkt_count unchanged, occupancy unchanged.
REQ-034 reset_n low during SEND of 4-flit packet after flit 2 -> all outputs 0 immediately, o_pkt_count=0, o_flit_ready=1 after release.

Source files
------------

// File: rtl/output_unit.sv
`default_nettype none
// ============================================================================
//  Module   : output_unit
//  Purpose  : Router output port. It buffers flits from the switch, requests
//             the downstream input port and streams one packet per grant.
//  Revision : 1.0
// ============================================================================

package router_pkg;
    localparam int FLIT_SIZE = 32;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'b01,
        BODY_FLIT = 2'b10,
        TAIL_FLIT = 2'b11
    } flit_type_t;

    typedef struct packed {
        logic                 valid;
        flit_type_t           flit_type;
        logic [FLIT_SIZE-4:0] payload;
    } tail_flit_t;

    typedef union packed {
        tail_flit_t           tail;
        logic [FLIT_SIZE-1:0] raw;
    } FLIT_t;
endpackage

module output_unit #(
    parameter int FLIT_SIZE = router_pkg::FLIT_SIZE,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  router_pkg::FLIT_t        i_flit,
    input  logic                     i_flit_push,
    output logic                     o_flit_ready,
    output router_pkg::FLIT_t        o_flit,
    output logic                     o_downstream_req,
    input  logic                     i_transmit_ack,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_pkt_count
);
    import router_pkg::*;

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_SEND    = 2'd2
    } state_t;

    FLIT_t             r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   r_pkt_count;
    state_t            r_state;
    state_t            w_next_state;
    FLIT_t             r_flit;
    FLIT_t             w_flit_next;
    FLIT_t             w_head;
    logic              r_req;
    logic              w_req_next;
    logic              r_busy;
    logic              w_push;
    logic              w_pop;
    logic              w_pop_en;
    logic              w_push_tail;
    logic              w_pop_tail;

    assign o_flit_ready     = (r_count != c_CW'(DEPTH));
    assign o_flit           = r_flit;
    assign o_downstream_req = r_req;
    assign o_busy           = r_busy;
    assign o_pkt_count      = r_pkt_count;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_push      = i_flit_push && o_flit_ready;
    assign w_pop_en    = w_pop && (r_count != '0);
    assign w_push_tail = w_push && (i_flit.tail.flit_type == TAIL_FLIT);
    assign w_pop_tail  = w_pop_en && (w_head.tail.flit_type == TAIL_FLIT);

    // The registered output flit tells SEND when the tail has gone out.
    always_comb begin
        w_next_state = r_state;
        w_req_next   = 1'b0;
        w_flit_next  = '0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pkt_count != '0) begin
                    w_next_state = S_REQUEST;
                    w_req_next   = 1'b1;
                end
            end
            S_REQUEST: begin
                w_req_next = 1'b1;
                if (i_transmit_ack) begin
                    w_next_state               = S_SEND;
                    w_req_next                 = 1'b0;
                    w_pop                      = 1'b1;
                    w_flit_next                = w_head;
                    w_flit_next.raw[FLIT_SIZE-1] = 1'b1;
                end
            end
            S_SEND: begin
                if (r_flit.tail.flit_type == TAIL_FLIT) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_pop                        = 1'b1;
                    w_flit_next                  = w_head;
                    w_flit_next.raw[FLIT_SIZE-1] = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_flit      <= '0;
            r_busy      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pkt_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_req       <= w_req_next;
            r_flit      <= w_flit_next;
            r_busy      <= (w_next_state != S_IDLE);
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop_en)
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count     <= r_count + c_CW'(w_push) - c_CW'(w_pop_en);
            r_pkt_count <= r_pkt_count + c_CW'(w_push_tail) - c_CW'(w_pop_tail);
        end
    end

    // Storage needs no reset: reset clears the pointers, discarding contents.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_flit;
    end

    a_no_pop_when_empty: assert property (
        @(posedge clk) disable iff (!reset_n) !(w_pop && (r_count == '0))
    );

endmodule

`default_nettype wire

// File: tb/tb_output_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_output_unit
//  Purpose  : Scoreboard bench for output_unit: stimulus queues expected
//             flits and status probes, a negedge monitor compares them.
//  Revision : 1.0
// ============================================================================
module tb_output_unit;
    import router_pkg::*;

    localparam int FS    = FLIT_SIZE;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_flit_push = 1'b0;
    logic        i_transmit_ack = 1'b0;
    FLIT_t       i_flit;
    FLIT_t       o_flit;
    logic        o_flit_ready;
    logic        o_downstream_req;
    logic        o_busy;
    logic [3:0]  o_pkt_count;

    output_unit #(.FLIT_SIZE(FS), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_flit           (i_flit),
        .i_flit_push      (i_flit_push),
        .o_flit_ready     (o_flit_ready),
        .o_flit           (o_flit),
        .o_downstream_req (o_downstream_req),
        .i_transmit_ack   (i_transmit_ack),
        .o_busy           (o_busy),
        .o_pkt_count      (o_pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic       busy;
        logic       ready;
        logic [3:0] cnt;
        logic       chk_zero;
    } probe_t;

    probe_t          probe_q[$];
    string           name_q[$];
    logic [FS-1:0]   exp_q[$];
    int              n_vec = 0;
    int              n_err = 0;
    bit              final_chk = 1'b0;
    bit              final_done = 1'b0;

    // Monitor: status probes, output flits and the end-of-run drain check.
    always @(negedge clk) begin
        probe_t        p;
        string         nm;
        logic [FS-1:0] e;
        if (probe_q.size() != 0) begin
            p  = probe_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (o_downstream_req !== p.req || o_busy !== p.busy ||
                o_flit_ready !== p.ready || o_pkt_count !== p.cnt ||
                (p.chk_zero && o_flit.raw !== '0)) begin
                n_err++;
                $display("FAIL %s: got req=%b busy=%b ready=%b cnt=%0d flit=%h, want req=%b busy=%b ready=%b cnt=%0d%s",
                         nm, o_downstream_req, o_busy, o_flit_ready, o_pkt_count, o_flit.raw,
                         p.req, p.busy, p.ready, p.cnt, p.chk_zero ? " flit=0" : "");
            end
        end
        if (o_flit.raw[FS-1] === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_flit: got %h, want no flit", o_flit.raw);
            end else begin
                e = exp_q.pop_front();
                if (o_flit.raw !== e) begin
                    n_err++;
                    $display("FAIL flit_data: got %h, want %h", o_flit.raw, e);
                end
            end
        end
        if (final_chk && !final_done) begin
            n_vec++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL missing_flits: got %0d flits still outstanding, want 0", exp_q.size());
            end
            final_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string nm, input logic req, input logic busy,
                         input logic ready, input logic [3:0] cnt, input logic z);
        probe_t p;
        p.req = req; p.busy = busy; p.ready = ready; p.cnt = cnt; p.chk_zero = z;
        probe_q.push_back(p);
        name_q.push_back(nm);
    endtask

    // Input valid bit is left 0; the DUT must force it to 1 on output.
    task automatic push(input logic [1:0] t, input logic [FS-4:0] pl, input bit expect_out);
        i_flit.raw  = {1'b0, t, pl};
        i_flit_push = 1'b1;
        if (expect_out)
            exp_q.push_back({1'b1, t, pl});
        tick();
        i_flit_push = 1'b0;
    endtask

    initial begin
        i_flit.raw = '0;
        @(negedge clk); #1;
        probe("in_reset", 0, 0, 1, 0, 1);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        tick();
        probe("after_reset", 0, 0, 1, 0, 1);

        // Three-flit packet, ack after a few cycles of waiting.
        push(HEAD_FLIT, 29'd1, 1);
        push(BODY_FLIT, 29'd2, 1);
        push(TAIL_FLIT, 29'd3, 1);
        probe("t1_tail_in", 0, 0, 1, 1, 1);
        tick(); probe("t1_req", 1, 1, 1, 1, 1);
        tick(); tick(); probe("t1_wait", 1, 1, 1, 1, 1);
        i_transmit_ack = 1'b1; tick(); i_transmit_ack = 1'b0;
        probe("t1_head", 0, 1, 1, 1, 0);
        tick(); probe("t1_body", 0, 1, 1, 1, 0);
        tick(); probe("t1_tail_out", 0, 1, 1, 0, 0);
        tick(); probe("t1_idle", 0, 0, 1, 0, 1);

        // Fill without a tail; the ninth push (a tail) must be dropped.
        push(HEAD_FLIT, 29'd16, 0);
        for (int i = 0; i < 7; i++) push(BODY_FLIT, 29'(17 + i), 0);
        probe("t2_full", 0, 0, 0, 0, 1);
        push(TAIL_FLIT, 29'd30, 0);
        probe("t2_drop", 0, 0, 0, 0, 1);
        tick(); probe("t2_hold", 0, 0, 0, 0, 1);
        @(negedge clk); #1 reset_n = 1'b0;
        probe("t2_reset", 0, 0, 1, 0, 1);
        @(negedge clk); #1 reset_n = 1'b1;
        tick(); probe("t2_after", 0, 0, 1, 0, 1);

        // Spurious ack in IDLE, then a long wait for the grant.
        i_transmit_ack = 1'b1;
        tick(); probe("t3_spur", 0, 0, 1, 0, 1);
        tick(); i_transmit_ack = 1'b0;
        push(HEAD_FLIT, 29'd40, 1);
        push(TAIL_FLIT, 29'd41, 1);
        probe("t3_buf", 0, 0, 1, 1, 1);
        for (int i = 0; i < 100; i++) begin
            tick(); probe("t3_wait", 1, 1, 1, 1, 1);
        end
        i_transmit_ack = 1'b1; tick(); i_transmit_ack = 1'b0;
        probe("t3_head", 0, 1, 1, 1, 0);
        tick(); probe("t3_tail", 0, 1, 1, 0, 0);
        tick(); probe("t3_idle", 0, 0, 1, 0, 1);

        // Two packets back to back with ack held high throughout.
        push(HEAD_FLIT, 29'd50, 1);
        push(TAIL_FLIT, 29'd51, 1);
        push(HEAD_FLIT, 29'd52, 1);
        push(TAIL_FLIT, 29'd53, 1);
        probe("t4_buf", 1, 1, 1, 2, 1);
        i_transmit_ack = 1'b1;
        tick(); probe("t4_h1", 0, 1, 1, 2, 0);
        tick(); probe("t4_t1", 0, 1, 1, 1, 0);
        tick(); probe("t4_gap", 0, 0, 1, 1, 1);
        tick(); probe("t4_rereq", 1, 1, 1, 1, 1);
        tick(); probe("t4_h2", 0, 1, 1, 1, 0);
        tick(); probe("t4_t2", 0, 1, 1, 0, 0);
        tick(); probe("t4_idle", 0, 0, 1, 0, 1);
        i_transmit_ack = 1'b0;

        // Tail pushed on the same edge a tail is popped.
        push(HEAD_FLIT, 29'd60, 1);
        push(TAIL_FLIT, 29'd61, 1);
        tick(); probe("t5_req", 1, 1, 1, 1, 1);
        i_transmit_ack = 1'b1; tick(); i_transmit_ack = 1'b0;
        probe("t5_head", 0, 1, 1, 1, 0);
        push(TAIL_FLIT, 29'd62, 1);
        probe("t5_swap", 0, 1, 1, 1, 0);
        tick(); probe("t5_gap", 0, 0, 1, 1, 1);
        tick(); probe("t5_req2", 1, 1, 1, 1, 1);
        i_transmit_ack = 1'b1; tick(); i_transmit_ack = 1'b0;
        probe("t5_single", 0, 1, 1, 0, 0);
        tick(); probe("t5_idle", 0, 0, 1, 0, 1);

        // Reset in the middle of a four-flit packet, after two flits out.
        push(HEAD_FLIT, 29'd70, 1);
        push(BODY_FLIT, 29'd71, 1);
        push(BODY_FLIT, 29'd72, 0);
        push(TAIL_FLIT, 29'd73, 0);
        tick(); probe("t6_req", 1, 1, 1, 1, 1);
        i_transmit_ack = 1'b1; tick(); i_transmit_ack = 1'b0;
        probe("t6_head", 0, 1, 1, 1, 0);
        tick(); probe("t6_body", 0, 1, 1, 1, 0);
        @(negedge clk); #1 reset_n = 1'b0;
        probe("t6_reset", 0, 0, 1, 0, 1);
        @(negedge clk); #1 reset_n = 1'b1;
        tick(); probe("t6_after", 0, 0, 1, 0, 1);

        // Stale flits must be gone: a lone tail goes out by itself.
        push(TAIL_FLIT, 29'd80, 1);
        tick(); probe("t7_req", 1, 1, 1, 1, 1);
        i_transmit_ack = 1'b1; tick(); i_transmit_ack = 1'b0;
        probe("t7_single", 0, 1, 1, 0, 0);
        tick(); probe("t7_idle", 0, 0, 1, 0, 1);

        for (int i = 0; i < 20 && (exp_q.size() != 0 || probe_q.size() != 0); i++) tick();
        final_chk = 1'b1;
        for (int i = 0; i < 5 && !final_done; i++) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
